datapath_param: RTL and testbench
=================================

DATAPATH_PARAM -- requirements
Module: datapath_param

Interface
REQ-001 Parameter DATA_W, default 8: width of registers, ALU, input channels and OutPort.
REQ-002 Parameter NB_REGS, default 16, power of two >= 2: register-file depth.
REQ-003 Parameter NB_IN, default 8, power of two >= 2: number of input channels packed in InPort.
REQ-004 Parameter SAT_MODE, default 0: 1 makes ADD/SUB saturate unsigned; 0 makes them wrap.
REQ-005 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 InPort  input  NB_IN*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 Sel  input  clog2(NB_IN)  input channel used by LOAD.
REQ-009 Wen  input  1  an instruction is issued this cycle.
REQ-010 WA / RAA / RAB  input  clog2(NB_REGS) each  destination, operand-A and operand-B register addresses.
REQ-011 Op  input  3  operation code.
REQ-012 OutEn  input  1  latch operand A into OutPort.
REQ-013 OutPort  output  DATA_W  registered output port.
REQ-014 Flag  output  1  registered zero flag of the last issued instruction.
REQ-015 Carry  output  1  registered carry/borrow flag of the last issued instruction.

Function
REQ-016 Op encoding SHALL be: 000 ADD A+B, 001 SUB A-B, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 PASS A, 111 LOAD InPort channel Sel.
REQ-017 Operands SHALL be read combinationally in the issue cycle; register 0 SHALL always read as 0.
REQ-018 The pipeline SHALL have two stages: the issue cycle registers the result, WA and a valid bit; the write-back cycle writes the register file at the next edge.
REQ-019 A write-back to WA=0 SHALL be discarded.
REQ-020 Latency: a result issued in cycle N SHALL be in the register file from cycle N+2.
REQ-021 Bypass: in cycle N+1, a read of the pending nonzero WA on RAA or RAB SHALL return the pending result instead of the register-file value.
REQ-022 Flag and Carry SHALL update at the edge ending an issue cycle; with Wen=0 they SHALL hold.
REQ-023 Carry SHALL be the carry out of bit DATA_W-1 for ADD, the borrow (A<B) for SUB, and 0 for every other op.
REQ-024 With SAT_MODE=1, ADD overflow SHALL yield all-ones and SUB underflow SHALL yield 0; Carry SHALL still report overflow or borrow.
REQ-025 Flag SHALL be 1 iff the final result, after saturation, is 0.
REQ-026 When OutEn=1, OutPort SHALL load the bypassed operand A at the next edge; otherwise it SHALL hold.
REQ-027 OutEn and Wen SHALL be independent and usable in the same cycle.

Reset
REQ-028 While rst=1 at an edge: all registers, the pipeline valid bit, OutPort, Flag and Carry SHALL become 0.
REQ-029 rst SHALL override Wen and OutEn in the same cycle.
REQ-030 A write-back pending when rst is asserted SHALL be discarded.

Structure
REQ-031 Package datapath_param_pkg SHALL hold the op_t enumeration for REQ-016 and the default parameter values.
REQ-032 The register file SHALL be sub-module regfile_param: NB_REGS x DATA_W, two asynchronous read ports, one synchronous write port, register 0 hardwired to 0.
REQ-033 The ALU, saturation logic, pipeline registers and bypass SHALL live in datapath_param.

Verification
All scenarios use the default parameters.
REQ-034 Bypass: InPort ch3=0x2A, Sel=3, LOAD WA=1; next cycle ADD RAA=RAB=1, WA=2 -> pending R2=0x54, Carry=0, Flag=0; then OutEn with RAA=2 -> OutPort=0x54.
REQ-035 Saturation: R1=0xF0, R2=0x20, ADD -> with SAT_MODE=0 result 0x10 and Carry=1; with SAT_MODE=1 result 0xFF and Carry=1.
REQ-036 SUB and zero flag: R3=0x05, R3-R3 -> result 0x00, Flag=1, Carry=0; then 0x05-0x07 -> result 0xFE, Carry=1, Flag=0.
REQ-037 Register 0: LOAD 0x77 to WA=0 -> R0 still reads 0, and bypass returns 0 for RAA=0 in the next cycle.
REQ-038 Reset: issue LOAD 0x33 to WA=4, assert rst in the next cycle -> R4=0, OutPort=0, Flag=0, Carry=0.
REQ-039 Hold: Wen=0 for 3 cycles after an ADD that set Carry=1 -> Flag and Carry unchanged and no register written.

Source files
------------

// File: rtl/datapath_param_pkg.sv
// Shared types and default parameter values for the parameterised two-stage datapath.
package datapath_param_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_NB_REGS  = 16;
  localparam int unsigned DEF_NB_IN    = 8;
  localparam int unsigned DEF_SAT_MODE = 0;
  localparam int unsigned OP_W         = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_PASS = 3'b110,
    OP_LOAD = 3'b111
  } op_t;

endpackage

// File: rtl/regfile_param.sv
// NB_REGS x DATA_W register file: two asynchronous read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module regfile_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NB_REGS = 16,
  localparam int unsigned AW     = $clog2(NB_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     raa,
  input  logic [AW-1:0]     rab,
  output logic [DATA_W-1:0] rda_c,
  output logic [DATA_W-1:0] rdb_c
);

  logic [DATA_W-1:0] mem [NB_REGS];

  // Reset wins over any pending write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NB_REGS); i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rda_c = (raa == '0) ? '0 : mem[raa];
  assign rdb_c = (rab == '0) ? '0 : mem[rab];

endmodule

// File: rtl/datapath_param.sv
// Two-stage datapath: issue (operand read + ALU + saturation) then register-file write-back,
// with a bypass from the pending write-back to both operand ports.
module datapath_param
  import datapath_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NB_REGS  = DEF_NB_REGS,
  parameter int unsigned NB_IN    = DEF_NB_IN,
  parameter int unsigned SAT_MODE = DEF_SAT_MODE,
  localparam int unsigned RA_W    = $clog2(NB_REGS),
  localparam int unsigned SEL_W   = $clog2(NB_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NB_IN*DATA_W-1:0] InPort,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    Wen,
  input  logic [RA_W-1:0]         WA,
  input  logic [RA_W-1:0]         RAA,
  input  logic [RA_W-1:0]         RAB,
  input  logic [OP_W-1:0]         Op,
  input  logic                    OutEn,
  output logic [DATA_W-1:0]       OutPort,
  output logic                    Flag,
  output logic                    Carry
);

  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic              pend_valid;
  logic [RA_W-1:0]   pend_wa;
  logic [DATA_W-1:0] pend_res;
  logic [DATA_W-1:0] in_ch [NB_IN];

  for (genvar k = 0; k < int'(NB_IN); k++) begin : g_ch
    assign in_ch[k] = InPort[k*DATA_W +: DATA_W];
  end

  regfile_param #(
    .DATA_W  (DATA_W),
    .NB_REGS (NB_REGS)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (pend_valid),
    .wa    (pend_wa),
    .wd    (pend_res),
    .raa   (RAA),
    .rab   (RAB),
    .rda_c (rf_a),
    .rdb_c (rf_b)
  );

  // Bypass the not-yet-written result; register 0 never forwards.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (pend_valid && (pend_wa != '0)) begin
      if (RAA == pend_wa) op_a = pend_res;
      if (RAB == pend_wa) op_b = pend_res;
    end
  end

  // ALU; the extra MSB of sum/diff is the carry out or the borrow (A < B).
  always_comb begin
    sum_ext   = {1'b0, op_a} + {1'b0, op_b};
    diff_ext  = {1'b0, op_a} - {1'b0, op_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_t'(Op))
      OP_ADD: begin
        alu_carry = sum_ext[DATA_W];
        alu_res   = ((SAT_MODE != 0) && alu_carry) ? '1 : sum_ext[DATA_W-1:0];
      end
      OP_SUB: begin
        alu_carry = diff_ext[DATA_W];
        alu_res   = ((SAT_MODE != 0) && alu_carry) ? '0 : diff_ext[DATA_W-1:0];
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_PASS: alu_res = op_a;
      OP_LOAD: alu_res = in_ch[Sel];
      default: alu_res = '0;
    endcase
  end

  // Issue-stage registers, status flags and output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_wa    <= '0;
      pend_res   <= '0;
      Flag       <= 1'b0;
      Carry      <= 1'b0;
      OutPort    <= '0;
    end else begin
      pend_valid <= Wen;
      if (Wen) begin
        pend_wa  <= WA;
        pend_res <= alu_res;
        Flag     <= (alu_res == '0);
        Carry    <= alu_carry;
      end
      if (OutEn) begin
        OutPort <= op_a;
      end
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench: wrap and saturating datapaths driven in lockstep and checked against an
// instruction-level model in which every instruction sees all earlier results immediately.
module tb_datapath_param;

  logic        clk;
  logic        rst;
  logic [63:0] InPort;
  logic [2:0]  Sel;
  logic        Wen;
  logic [3:0]  WA, RAA, RAB;
  logic [2:0]  Op;
  logic        OutEn;
  logic [7:0]  out0, out1;
  logic        flag0, flag1, carry0, carry1;

  typedef struct {
    logic [7:0] out0;
    logic [7:0] out1;
    logic       f0, c0, f1, c1;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_regs [2][16];
  int m_out  [2];
  int m_flag [2];
  int m_carry[2];

  datapath_param #(.SAT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .InPort(InPort), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA),
    .RAB(RAB), .Op(Op), .OutEn(OutEn), .OutPort(out0), .Flag(flag0), .Carry(carry0)
  );

  datapath_param #(.SAT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .InPort(InPort), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA),
    .RAB(RAB), .Op(Op), .OutEn(OutEn), .OutPort(out1), .Flag(flag1), .Carry(carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] ch(input int k, input int v);
    logic [63:0] r;
    r = '0;
    r[k*8 +: 8] = 8'(v);
    return r;
  endfunction

  // Plain-arithmetic reference for one instruction on 8-bit unsigned values.
  function automatic void alu_model(input int op, input int a, input int b, input int inval,
                                    input int sat, output int res, output int c);
    res = 0;
    c   = 0;
    case (op)
      0: begin
        res = a + b;
        c   = (res > 255) ? 1 : 0;
        if (c != 0) res = (sat != 0) ? 255 : res - 256;
      end
      1: begin
        c   = (a < b) ? 1 : 0;
        res = (c == 0) ? a - b : ((sat != 0) ? 0 : a - b + 256);
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: res = a;
      default: res = inval;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected post-edge state.
  task automatic step(input bit r, input bit w, input bit oe, input int op, input int wa,
                      input int raa, input int rab, input int sel, input logic [63:0] inp);
    exp_t e;
    int a, b, res, c;
    rst = r; Wen = w; OutEn = oe; Op = 3'(op); WA = 4'(wa); RAA = 4'(raa); RAB = 4'(rab);
    Sel = 3'(sel); InPort = inp;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int i = 0; i < 16; i++) m_regs[d][i] = 0;
        m_out[d] = 0; m_flag[d] = 0; m_carry[d] = 0;
      end else begin
        a = m_regs[d][raa];
        b = m_regs[d][rab];
        if (oe) m_out[d] = a;
        if (w) begin
          alu_model(op, a, b, int'(inp[sel*8 +: 8]), d, res, c);
          m_flag[d]  = (res == 0) ? 1 : 0;
          m_carry[d] = c;
          if (wa != 0) m_regs[d][wa] = res;
        end
      end
    end
    e.out0 = 8'(m_out[0]); e.f0 = 1'(m_flag[0]); e.c0 = 1'(m_carry[0]);
    e.out1 = 8'(m_out[1]); e.f1 = 1'(m_flag[1]); e.c1 = 1'(m_carry[1]);
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge produces one observable state to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got no queued entry, expected one at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sb_out0",   out0,           e.out0);
        chk("sb_flag0",  {7'b0, flag0},  {7'b0, e.f0});
        chk("sb_carry0", {7'b0, carry0}, {7'b0, e.c0});
        chk("sb_out1",   out1,           e.out1);
        chk("sb_flag1",  {7'b0, flag1},  {7'b0, e.f1});
        chk("sb_carry1", {7'b0, carry1}, {7'b0, e.c1});
      end
    end
  end

  initial begin
    int op, v;
    logic [63:0] inp;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 64'h0);
    chk("reset_out", out0, 8'h00);
    chk("reset_flag", {7'b0, flag0}, 8'h00);

    // Bypass: LOAD 0x2A into R1, then R1+R1 into R2, then emit R2.
    step(0, 1, 0, 7, 1, 0, 0, 3, ch(3, 8'h2A));
    step(0, 1, 0, 0, 2, 1, 1, 0, 64'h0);
    chk("byp_flag", {7'b0, flag0}, 8'h00);
    chk("byp_carry", {7'b0, carry0}, 8'h00);
    step(0, 0, 1, 0, 0, 2, 0, 0, 64'h0);
    chk("byp_out", out0, 8'h54);

    // Saturation: 0xF0 + 0x20.
    step(0, 1, 0, 7, 1, 0, 0, 0, ch(0, 8'hF0));
    step(0, 1, 0, 7, 2, 0, 0, 1, ch(1, 8'h20));
    step(0, 1, 0, 0, 3, 1, 2, 0, 64'h0);
    chk("sat_carry0", {7'b0, carry0}, 8'h01);
    chk("sat_carry1", {7'b0, carry1}, 8'h01);
    step(0, 0, 1, 0, 0, 3, 0, 0, 64'h0);
    chk("wrap_out", out0, 8'h10);
    chk("sat_out", out1, 8'hFF);

    // Hold: Wen low for three cycles, WA pointing at R1 with a LOAD opcode.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 7, 1, 0, 0, 5, ch(5, 8'h99));
      chk("hold_carry", {7'b0, carry0}, 8'h01);
      chk("hold_flag", {7'b0, flag0}, 8'h00);
    end
    step(0, 0, 1, 0, 0, 1, 0, 0, 64'h0);
    chk("hold_r1", out0, 8'hF0);

    // SUB and zero flag.
    step(0, 1, 0, 7, 3, 0, 0, 0, ch(0, 8'h05));
    step(0, 1, 0, 1, 4, 3, 3, 0, 64'h0);
    chk("sub_zero_flag", {7'b0, flag0}, 8'h01);
    chk("sub_zero_carry", {7'b0, carry0}, 8'h00);
    step(0, 1, 0, 7, 5, 0, 0, 0, ch(0, 8'h07));
    step(0, 1, 0, 1, 6, 3, 5, 0, 64'h0);
    chk("sub_borrow", {7'b0, carry0}, 8'h01);
    chk("sub_flag", {7'b0, flag0}, 8'h00);
    step(0, 0, 1, 0, 0, 6, 0, 0, 64'h0);
    chk("sub_out_wrap", out0, 8'hFE);
    chk("sub_out_sat", out1, 8'h00);

    // Register 0 discards writes and never forwards.
    step(0, 1, 0, 7, 0, 0, 0, 2, ch(2, 8'h77));
    step(0, 0, 1, 0, 0, 0, 0, 0, 64'h0);
    chk("r0_bypass", out0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 0, 0, 64'h0);
    chk("r0_read", out0, 8'h00);

    // Reset drops the pending write-back and overrides Wen/OutEn.
    step(0, 1, 1, 7, 4, 1, 0, 4, ch(4, 8'h33));
    chk("pre_rst_out", out0, 8'hF0);
    step(1, 1, 1, 7, 4, 1, 0, 4, ch(4, 8'h33));
    chk("rst_out", out0, 8'h00);
    chk("rst_flag", {7'b0, flag0}, 8'h00);
    chk("rst_carry", {7'b0, carry0}, 8'h00);
    step(0, 0, 1, 0, 0, 4, 0, 0, 64'h0);
    chk("rst_r4", out0, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      inp = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) begin
        v = int'($urandom_range(0, 7));
        if (v == 0) inp[k*8 +: 8] = 8'h00;
        else if (v == 1) inp[k*8 +: 8] = 8'hFF;
      end
      op = int'($urandom_range(0, 7));
      step(($urandom_range(0, 63) == 0), bit'($urandom_range(0, 1) | (op == 7)),
           bit'($urandom_range(0, 1)), op, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 7)), inp);
    end

    #2;
    chk("sb_drained", 8'(q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
